// File: rtl/div_dispatch.sv
// Request front-end for the Q16.16 divider: tagged operand FIFO, one-at-a-time issue, tagged result hold.
// Optional completion watchdog enabled by defining DIV_TIMEOUT_EN.
module div_dispatch #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    input  logic                     div_done,
    input  logic                     div_valid,
    input  logic                     div_dbz,
    input  logic                     div_ovf,
    input  logic [WIDTH-1:0]         div_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_val,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_dbz,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [WIDTH-1:0]   mem_a_r   [DEPTH];
    logic [WIDTH-1:0]   mem_b_r   [DEPTH];
    logic [TAG_W-1:0]   mem_tag_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               in_ready_s;
    logic               push_s;
    logic               pop_s;
    logic               cap_s;

    logic [TAG_W-1:0]   tag_r;
    logic [WIDTH-1:0]   div_a_r;
    logic [WIDTH-1:0]   div_b_r;
    logic               div_start_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_val_r;
    logic [TAG_W-1:0]   out_tag_r;
    logic               out_dbz_r;
    logic               out_ovf_r;

`ifdef DIV_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMR_W-1:0]   tmr_r;
    logic               tmo_s;
`endif

    // Full flag comes from the occupancy register only, so pop never feeds in_ready.
    assign in_ready_s = (count_r != CNT_W'(DEPTH));
    assign push_s     = in_valid && in_ready_s;

    // Next-state and control strobes for the issue FSM.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        cap_s   = 1'b0;
`ifdef DIV_TIMEOUT_EN
        tmo_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    cap_s   = 1'b1;
                    state_s = HOLD;
                end
`ifdef DIV_TIMEOUT_EN
                else if (tmr_r == TMR_W'(TIMEOUT - 1)) begin
                    tmo_s   = 1'b1;
                    state_s = HOLD;
                end
`endif
                else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request FIFO storage, pointers and occupancy; pointers wrap on the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i]   <= {WIDTH{1'b0}};
                mem_b_r[i]   <= {WIDTH{1'b0}};
                mem_tag_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_a_r[wr_ptr_r]   <= in_a;
                mem_b_r[wr_ptr_r]   <= in_b;
                mem_tag_r[wr_ptr_r] <= in_tag;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef DIV_TIMEOUT_EN
    // Watchdog counts WAIT cycles from entry and restarts whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if (state_r != WAIT) begin
            tmr_r <= {TMR_W{1'b0}};
        end else begin
            tmr_r <= tmr_r + TMR_W'(1);
        end
    end
`endif

    // Operand issue and result capture; operands stay put until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_start_r <= 1'b0;
            div_a_r     <= {WIDTH{1'b0}};
            div_b_r     <= {WIDTH{1'b0}};
            tag_r       <= {TAG_W{1'b0}};
            out_valid_r <= 1'b0;
            out_val_r   <= {WIDTH{1'b0}};
            out_tag_r   <= {TAG_W{1'b0}};
            out_dbz_r   <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else begin
            div_start_r <= pop_s;
            if (pop_s) begin
                div_a_r <= mem_a_r[rd_ptr_r];
                div_b_r <= mem_b_r[rd_ptr_r];
                tag_r   <= mem_tag_r[rd_ptr_r];
            end
            if (cap_s) begin
                out_valid_r <= 1'b1;
                out_val_r   <= div_valid ? div_val : {WIDTH{1'b0}};
                out_tag_r   <= tag_r;
                out_dbz_r   <= div_dbz;
                out_ovf_r   <= div_ovf;
            end
`ifdef DIV_TIMEOUT_EN
            else if (tmo_s) begin
                out_valid_r <= 1'b1;
                out_val_r   <= {WIDTH{1'b0}};
                out_tag_r   <= tag_r;
                out_dbz_r   <= 1'b0;
                out_ovf_r   <= 1'b1;
            end
`endif
            else if ((state_r == HOLD) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign count     = count_r;
    assign div_start = div_start_r;
    assign div_a     = div_a_r;
    assign div_b     = div_b_r;
    assign out_valid = out_valid_r;
    assign out_val   = out_val_r;
    assign out_tag   = out_tag_r;
    assign out_dbz   = out_dbz_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_div_dispatch.sv
// Randomized bench for div_dispatch: behavioural divider, Q16.16 reference and in-order scoreboard.
// Timeout scenario is compiled in when DIV_TIMEOUT_EN is defined.
module tb_div_dispatch;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int D  = 4;
    localparam int TO = 64;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          div_start;
    logic [W-1:0]  div_a;
    logic [W-1:0]  div_b;
    logic          div_done;
    logic          div_valid;
    logic          div_dbz;
    logic          div_ovf;
    logic [W-1:0]  div_val;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_val;
    logic [TW-1:0] out_tag;
    logic          out_dbz;
    logic          out_ovf;
    logic [$clog2(D):0] count;

    div_dispatch #(.WIDTH(W), .TAG_W(TW), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_valid(div_valid), .div_dbz(div_dbz), .div_ovf(div_ovf), .div_val(div_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_tag(out_tag),
        .out_dbz(out_dbz), .out_ovf(out_ovf), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Q16.16 signed division from first principles: {dbz, ovf, quotient}.
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint n;
        longint r;
        if (b == 32'd0) return {1'b1, 1'b0, 32'd0};
        n = longint'($signed(a)) * 64'sd65536;
        r = n / longint'($signed(b));
        if (r > 64'sd2147483647 || r < -64'sd2147483648) return {1'b0, 1'b1, 32'd0};
        return {1'b0, 1'b0, r[31:0]};
    endfunction

    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  tag;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] issue_q[$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- behavioural divider ----------------
    int  lat_min = 51;
    int  lat_max = 51;
    bit  no_done = 1'b0;
    bit  stray_en = 1'b0;
    int  ready_mode = 0;

    initial begin
        bit          busy;
        int          rem;
        logic [31:0] sa, sb;
        logic [33:0] r;
        busy = 1'b0;
        rem = 0;
        div_done = 1'b0; div_valid = 1'b0; div_dbz = 1'b0; div_ovf = 1'b0; div_val = 32'd0;
        forever begin
            @(posedge clk); #2;
            div_done = 1'b0; div_valid = 1'b0; div_dbz = 1'b0; div_ovf = 1'b0;
            div_val = $urandom;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (!busy && stray_en && ($urandom_range(7, 0) == 0)) begin
                    div_done = 1'b1; div_valid = 1'(($urandom_range(1, 0)));
                    div_dbz = 1'($urandom_range(1, 0)); div_ovf = 1'($urandom_range(1, 0));
                end
                if (busy) begin
                    rem--;
                    if (rem == 0) begin
                        busy = 1'b0;
                        r = ref_div(sa, sb);
                        div_done = 1'b1;
                        div_dbz = r[33];
                        div_ovf = r[32];
                        div_valid = !(r[33] | r[32]);
                        if (div_valid) div_val = r[31:0];
                    end
                end
                if (div_start && !no_done) begin
                    sa = div_a; sb = div_b;
                    r = ref_div(sa, sb);
                    busy = 1'b1;
                    rem = (r[33] | r[32]) ? 1 : $urandom_range(lat_max, lat_min);
                end
            end
        end
    end

    // Consumer back-pressure: 0 always ready, 1 random, 2 held low.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          n_out = 0;
    int          n_starts = 0;
    int          last_push_cyc = 0;
    int          last_start_cyc = 0;
    int          first_out_cyc = 0;
    logic [31:0] last_val;
    logic [3:0]  last_tag;
    logic        last_dbz, last_ovf;
    bit          flight = 1'b0;

    initial begin
        bit          prev_hold, prev_start, prev_ov;
        logic [31:0] pv, fa, fb;
        logic [3:0]  pt;
        logic        pd, po;
        exp_t        e;
        logic [33:0] r;
        prev_hold = 1'b0; prev_start = 1'b0; prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0; prev_start = 1'b0; prev_ov = 1'b0; flight = 1'b0;
            end else begin
                check("ready_vs_full", in_ready, (count != D));
                check("count_le_depth", (count <= D), 1);
                if (prev_hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_val", out_val, pv);
                    check("hold_tag", out_tag, pt);
                    check("hold_flags", {out_dbz, out_ovf}, {pd, po});
                end
                if (flight) begin
                    check("div_a_stable", div_a, fa);
                    check("div_b_stable", div_b, fb);
                end
                if (div_start) begin
                    n_starts++;
                    last_start_cyc = cyc;
                    check("start_pulse_width", prev_start, 0);
                    check("start_while_out", out_valid, 0);
                    if (issue_q.size() == 0) check("start_unexpected", 1, 0);
                    else check("issue_operands", {div_a, div_b}, issue_q.pop_front());
                    flight = 1'b1; fa = div_a; fb = div_b;
                end
                if (out_valid && !prev_ov) begin
                    first_out_cyc = cyc;
                    flight = 1'b0;
                end
                if (in_valid && in_ready) begin
                    last_push_cyc = cyc;
                    issue_q.push_back({in_a, in_b});
                    r = ref_div(in_a, in_b);
                    if (no_done) e = '{q: 32'd0, tag: in_tag, dbz: 1'b0, ovf: 1'b1};
                    else e = '{q: r[31:0], tag: in_tag, dbz: r[33], ovf: r[32]};
                    exp_q.push_back(e);
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    last_val = out_val; last_tag = out_tag; last_dbz = out_dbz; last_ovf = out_ovf;
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_val", out_val, e.q);
                        check("out_tag", out_tag, e.tag);
                        check("out_dbz", out_dbz, e.dbz);
                        check("out_ovf", out_ovf, e.ovf);
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_start = div_start;
                prev_ov = out_valid;
                pv = out_val; pt = out_tag; pd = out_dbz; po = out_ovf;
            end
        end
    end

    // ---------------- stimulus helpers (caller sits at posedge+2) ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bit acc;
        acc = 1'b0;
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #2;
            if (acc) break;
        end
        check("push_accepted", acc, 1);
    endtask

    task automatic wait_outs(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_out >= n) break;
            step(1);
        end
        check("wait_outputs", (n_out >= n), 1);
    endtask

    task automatic wait_start(input int s0, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_starts > s0) break;
            step(1);
        end
        check("wait_start", (n_starts > s0), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_count"}, count, 0);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_div_ab"}, {div_a, div_b}, 64'd0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_val"}, out_val, 0);
        check({tag, "_out_tag"}, out_tag, 0);
        check({tag, "_out_flags"}, {out_dbz, out_ovf}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_out=%0d", n_out);
        $fatal(1);
    end

    initial begin
        int s0, o0;
        logic [31:0] a, b;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_tag = 4'd0;
        #1;
        check_reset_values("rst");
        step(3);
        rst_n = 1'b1;
        step(2);
        check_reset_values("post_rst");

        // Directed: 3.0 / 2.0, with latency from push to start.
        ready_mode = 0;
        s0 = n_starts;
        push(32'h00030000, 32'h00020000, 4'd3);
        in_valid = 1'b0;
        wait_start(s0, 20);
        check("start_latency", last_start_cyc - last_push_cyc, 2);
        wait_outs(1, 200);
        check("t1_val", last_val, 32'h00018000);
        check("t1_tag", last_tag, 3);
        check("t1_flags", {last_dbz, last_ovf}, 0);
        check("t1_one_start", n_starts - s0, 1);

        // Directed: -1.0 / 4.0, divide by zero, overflow.
        push(32'hFFFF0000, 32'h00040000, 4'd5);
        in_valid = 1'b0;
        wait_outs(2, 200);
        check("t2_val", last_val, 32'hFFFFC000);
        check("t2_flags", {last_dbz, last_ovf}, 0);
        push(32'h00050000, 32'h00000000, 4'd6);
        in_valid = 1'b0;
        wait_outs(3, 200);
        check("t3_dbz", {last_dbz, last_ovf, last_val}, {1'b1, 1'b0, 32'd0});
        push(32'h80000000, 32'h00008000, 4'd7);
        in_valid = 1'b0;
        wait_outs(4, 200);
        check("t3_ovf", {last_dbz, last_ovf, last_val}, {1'b0, 1'b1, 32'd0});

        // FIFO full while the divider is busy with an earlier request.
        lat_min = 40; lat_max = 40;
        s0 = n_starts;
        push(32'h00010000, 32'h00010000, 4'd15);
        in_valid = 1'b0;
        wait_start(s0, 20);
        for (int t = 0; t < 4; t++) push(32'h00010000 * (t + 1), 32'h00020000, 4'(t));
        in_a = 32'h00050000; in_b = 32'h00020000; in_tag = 4'd4; in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_count", count, 4);
        step(5);
        check("full_count_held", count, 4);
        push(32'h00050000, 32'h00020000, 4'd4);
        in_valid = 1'b0;
        wait_outs(10, 1000);
        check("order_last_tag", last_tag, 4);

        // Back-pressure: result held, nothing issued while out_ready is low.
        lat_min = 5; lat_max = 5;
        ready_mode = 2;
        o0 = n_out;
        push(32'h00070000, 32'h00030000, 4'd8);
        push(32'h00090000, 32'hFFFD0000, 4'd9);
        in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) break;
            step(1);
        end
        check("hold_seen", out_valid, 1);
        s0 = n_starts;
        step(10);
        check("hold_no_start", n_starts, s0);
        check("hold_still_valid", out_valid, 1);
        ready_mode = 0;
        wait_start(s0, 20);
        wait_outs(o0 + 2, 200);

`ifdef DIV_TIMEOUT_EN
        // Watchdog completion with the divider never answering.
        no_done = 1'b1;
        o0 = n_out;
        s0 = n_starts;
        push(32'h00010000, 32'h00030000, 4'd10);
        in_valid = 1'b0;
        wait_start(s0, 20);
        wait_outs(o0 + 1, 200);
        check("timeout_latency", first_out_cyc - last_start_cyc, TO + 1);
        check("timeout_flags", {last_dbz, last_ovf, last_val}, {1'b0, 1'b1, 32'd0});
        no_done = 1'b0;
        step(3);
`endif

        // Randomized traffic with back-pressure, stray completions and variable latency.
        lat_min = 1; lat_max = 60;
        ready_mode = 1;
        stray_en = 1'b1;
        o0 = n_out;
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            case ($urandom_range(7, 0))
                0:       b = 32'd0;
                1:       b = $urandom & 32'h000000FF;
                2:       begin a = a & 32'h000FFFFF; b = $urandom & 32'h000FFFFF; end
                default: b = $urandom;
            endcase
            push(a, b, 4'($urandom));
            if ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                step($urandom_range(3, 0));
            end
        end
        in_valid = 1'b0;
        wait_outs(o0 + 40, 5000);
        stray_en = 1'b0;
        ready_mode = 0;
        check("scoreboard_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of WAIT.
        no_done = 1'b1;
        s0 = n_starts;
        push(32'h00020000, 32'h00010000, 4'd12);
        push(32'h00040000, 32'h00010000, 4'd13);
        in_valid = 1'b0;
        wait_start(s0, 20);
        step(3);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        exp_q.delete();
        issue_q.delete();
        step(2);
        rst_n = 1'b1;
        no_done = 1'b0;
        step(2);
        check_reset_values("after_mid_rst");
        o0 = n_out;
        push(32'h00060000, 32'h00030000, 4'd14);
        in_valid = 1'b0;
        wait_outs(o0 + 1, 200);
        check("resume_val", last_val, 32'h00020000);
        check("resume_tag", last_tag, 14);
        step(5);
        check("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_dispatch.md
Name: div_dispatch

Overview:
Request front-end for the Q16.16 divider. Buffers tagged operand pairs in a small FIFO and issues them one at a time to the divider with a start pulse. Captures each completion (quotient plus dbz/ovf flags) into a tagged output register with valid/ready handshake. Sits between the pricing datapath's operand producers and the divider; one divider per instance.

Parameters:
WIDTH, 32, operand/result width (Q16.16)
TAG_W, 4, request tag width, returned unchanged with the result
DEPTH, 4, input FIFO entries; power of two, >= 2
TIMEOUT, 64, divider completion watchdog in cycles (used only with DIV_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request present
in_ready  out  1  FIFO can accept (= not full)
in_a  in  WIDTH  dividend, Q16.16 signed
in_b  in  WIDTH  divisor, Q16.16 signed
in_tag  in  TAG_W  request tag
div_start  out  1  one-cycle start pulse to divider
div_a  out  WIDTH  dividend to divider, registered
div_b  out  WIDTH  divisor to divider, registered
div_done  in  1  divider completion pulse
div_valid  in  1  divider result valid
div_dbz  in  1  divider divide-by-zero flag
div_ovf  in  1  divider overflow flag
div_val  in  WIDTH  divider quotient
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_val  out  WIDTH  quotient, Q16.16
out_tag  out  TAG_W  tag of the request
out_dbz  out  1  divide-by-zero
out_ovf  out  1  overflow (or timeout, see feature)
count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async): FIFO empty, count=0, in_ready=1, state IDLE, div_start=0, div_a=div_b=0, out_valid=0, out_val=0, out_tag=0, out_dbz=0, out_ovf=0. Reset mid-operation discards queued and in-flight requests; divider reset is driven from the same rst_n, inverted at integration.
- FIFO: push when in_valid && in_ready. in_ready = (count != DEPTH), registered-state only, no combinational path from pop. Push and pop in same cycle allowed; count unchanged. Order preserved.
- FSM states IDLE, ISSUE, WAIT, HOLD:
  - IDLE: if count != 0, pop head into div_a/div_b and tag register -> ISSUE.
  - ISSUE: div_start=1 for exactly this cycle -> WAIT. div_a/div_b held stable from ISSUE until leaving WAIT.
  - WAIT: on div_done: out_val = div_val if div_valid else 0; out_dbz=div_dbz; out_ovf=div_ovf; out_tag=tag; out_valid=1 next cycle -> HOLD.
  - HOLD: outputs stable while out_valid && !out_ready. On out_ready: out_valid=0 -> IDLE.
- Latency: request pushed into empty FIFO at cycle 0 -> div_start high at cycle 2 -> out_valid the cycle after div_done. Divider busy ~51 cycles for normal division, 1 cycle for dbz/ovf early-out.
- Only one request in flight. div_done outside WAIT is ignored.
- out_val forced to 0 whenever div_valid is low at completion (dbz/ovf), never stale.
- FIFO full: in_ready=0, in_valid ignored, no overwrite. FIFO empty in IDLE: stay IDLE, div_start=0.
- Pointer wrap: DEPTH power of two, pointers wrap naturally.

Optional Feature:
DIV_TIMEOUT_EN. When defined: WAIT counts cycles from entry. If TIMEOUT cycles pass with no div_done, the request completes with out_val=0, out_dbz=0, out_ovf=1 -> HOLD. A later stray div_done is ignored. When undefined: WAIT waits indefinitely and there is no counter logic.

Test Plan:
- push a=0x00030000, b=0x00020000, tag=3 with out_ready=1 -> one div_start at cycle 2; out_val=0x00018000, tag=3, dbz=0, ovf=0.
- push a=0xFFFF0000, b=0x00040000 -> out_val=0xFFFFC000, flags 0.
- push b=0 -> out_dbz=1, out_val=0; push a=0x80000000 -> out_ovf=1, out_val=0.
- 5 back-to-back pushes, tags 0..4, with divider busy -> 5th stalls (in_ready=0, count=4). Results return in tag order 0..4.
- out_ready held low 10 cycles after completion -> out_valid/out_val/out_tag stable and no new div_start. Release -> next request issues.
- With DIV_TIMEOUT_EN and div_done tied low -> out_valid 65 cycles after div_start with out_ovf=1. rst_n low mid-WAIT -> all outputs return to reset values immediately.
